// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-factor stream for an N-point radix-2 DIT FFT: quarter-wave cosine table,
// stage/butterfly sequencing and a two-stage valid/ready pipeline to the butterflies.
module fft_twiddle_sequencer #(
  parameter int N_POINTS  = 64,
  parameter int TW_WIDTH  = 9,
  parameter int FRAC_BITS = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_inverse,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_tw_valid,
  input  logic                                i_tw_ready,
  output logic [TW_WIDTH-1:0]                 o_tw_re,
  output logic [TW_WIDTH-1:0]                 o_tw_im,
  output logic [$clog2($clog2(N_POINTS))-1:0] o_tw_stage,
  output logic [$clog2(N_POINTS)-2:0]         o_tw_index,
  output logic                                o_tw_last
);

  localparam int L  = $clog2(N_POINTS);
  localparam int IW = L - 1;
  localparam int SW = $clog2(L);
  localparam int Q  = N_POINTS / 4;
  localparam int MW = FRAC_BITS + 1;
  localparam real C_PI = 3.14159265358979323846;

  localparam logic [SW-1:0]       C_LAST_S  = SW'(L - 1);
  localparam logic [IW-1:0]       C_LAST_B  = {IW{1'b1}};
  localparam logic [IW-1:0]       C_Q       = IW'(Q);
  localparam logic [MW-1:0]       C_ONE     = {1'b1, {FRAC_BITS{1'b0}}};
  localparam logic [TW_WIDTH-1:0] C_MAX_POS = TW_WIDTH'((1 << FRAC_BITS) - 1);

  // state | meaning
  // IDLE  | waiting for start, pipeline empty
  // RUN   | issuing (stage, butterfly) pairs into the pipeline
  // FLUSH | all pairs issued, draining until the last twiddle handshakes
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  function automatic logic [MW-1:0] cos_mag(input int j);
    real x;
    int  v;
    x = (2.0 ** FRAC_BITS) * $cos(2.0 * C_PI * real'(j) / real'(N_POINTS));
    v = $rtoi(x + 0.5);
    return v[MW-1:0];
  endfunction

  logic [MW-1:0] w_tab [0:Q];

  for (genvar j = 0; j <= Q; j++) begin : g_tab
    localparam logic [MW-1:0] C_T = cos_mag(j);
    assign w_tab[j] = C_T;
  end

  logic [1:0]          r_state;
  logic [SW-1:0]       r_s;
  logic [IW-1:0]       r_b;
  logic                r_inverse;

  logic                r_p1_valid;
  logic [SW-1:0]       r_p1_stage;
  logic [IW-1:0]       r_p1_index;
  logic                r_p1_last;
  logic [MW-1:0]       r_p1_cmag;
  logic [MW-1:0]       r_p1_smag;
  logic                r_p1_cneg;

  logic                r_tw_valid;
  logic [TW_WIDTH-1:0] r_tw_re;
  logic [TW_WIDTH-1:0] r_tw_im;
  logic [SW-1:0]       r_tw_stage;
  logic [IW-1:0]       r_tw_index;
  logic                r_tw_last;

  logic                w_stall;
  logic                w_adv;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_done;
  logic [IW:0]         w_mask;
  logic [SW-1:0]       w_shamt;
  logic [IW-1:0]       w_k;
  logic [IW-1:0]       w_kp;
  logic                w_k_hi;
  logic [MW-1:0]       w_cmag;
  logic [MW-1:0]       w_smag;
  logic [TW_WIDTH-1:0] w_c_ext;
  logic [TW_WIDTH-1:0] w_s_ext;
  logic [TW_WIDTH-1:0] w_re;
  logic [TW_WIDTH-1:0] w_im;

  always_comb begin
    w_stall      = r_tw_valid && !i_tw_ready;
    w_adv        = !w_stall;
    w_issue      = w_adv && (((r_state == S_IDLE) && i_start) || (r_state == S_RUN));
    w_issue_last = (r_s == C_LAST_S) && (r_b == C_LAST_B);
    w_done       = (r_state == S_FLUSH) && r_tw_valid && r_tw_last && i_tw_ready;
  end

  // Butterfly b of stage s uses exponent (b mod 2^s) * N/2^(s+1).
  always_comb begin
    w_mask  = ((IW+1)'(1) << r_s) - (IW+1)'(1);
    w_shamt = C_LAST_S - r_s;
    w_k     = (r_b & w_mask[IW-1:0]) << w_shamt;
    w_k_hi  = (w_k > C_Q);
    w_kp    = w_k - C_Q;
    w_cmag  = '0;
    w_smag  = '0;
    if (w_k_hi) begin
      w_cmag = w_tab[C_Q - w_kp];
      w_smag = w_tab[w_kp];
    end else begin
      w_cmag = w_tab[w_k];
      w_smag = w_tab[C_Q - w_k];
    end
  end

  // Sign is applied after the magnitude; only +1.0 needs saturating, -1.0 is representable.
  always_comb begin
    w_c_ext = TW_WIDTH'(r_p1_cmag);
    w_s_ext = TW_WIDTH'(r_p1_smag);
    w_re    = '0;
    w_im    = '0;
    if (r_p1_cneg) begin
      w_re = -w_c_ext;
    end else if (r_p1_cmag == C_ONE) begin
      w_re = C_MAX_POS;
    end else begin
      w_re = w_c_ext;
    end
    if (!r_inverse) begin
      w_im = -w_s_ext;
    end else if (r_p1_smag == C_ONE) begin
      w_im = C_MAX_POS;
    end else begin
      w_im = w_s_ext;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_s        <= '0;
      r_b        <= '0;
      r_inverse  <= 1'b0;
      r_p1_valid <= 1'b0;
      r_p1_stage <= '0;
      r_p1_index <= '0;
      r_p1_last  <= 1'b0;
      r_p1_cmag  <= '0;
      r_p1_smag  <= '0;
      r_p1_cneg  <= 1'b0;
      r_tw_valid <= 1'b0;
      r_tw_re    <= '0;
      r_tw_im    <= '0;
      r_tw_stage <= '0;
      r_tw_index <= '0;
      r_tw_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_inverse <= i_inverse;
          end
        end
        S_RUN: begin
          if (w_issue && w_issue_last) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        if (w_issue_last) begin
          r_s <= '0;
          r_b <= '0;
        end else if (r_b == C_LAST_B) begin
          r_b <= '0;
          r_s <= r_s + SW'(1);
        end else begin
          r_b <= r_b + IW'(1);
        end
      end

      if (w_adv) begin
        r_p1_valid <= w_issue;
        r_p1_stage <= r_s;
        r_p1_index <= w_k;
        r_p1_last  <= w_issue_last;
        r_p1_cmag  <= w_cmag;
        r_p1_smag  <= w_smag;
        r_p1_cneg  <= w_k_hi;
        r_tw_valid <= r_p1_valid;
        r_tw_re    <= w_re;
        r_tw_im    <= w_im;
        r_tw_stage <= r_p1_stage;
        r_tw_index <= r_p1_index;
        r_tw_last  <= r_p1_last && r_p1_valid;
      end
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = w_done;
  assign o_tw_valid = r_tw_valid;
  assign o_tw_re    = r_tw_re;
  assign o_tw_im    = r_tw_im;
  assign o_tw_stage = r_tw_stage;
  assign o_tw_index = r_tw_index;
  assign o_tw_last  = r_tw_last;

endmodule
